// File: rtl/lp_dma_rd_pkg.sv
// LP20 DMA read engine: shared types and constants (package lp_pkg).
// Holds the state encoding, the address/count widths, the default NXM
// timeout and the byte-lane extraction also used by the checksum logic.
package lp_pkg;

  localparam int LP_BAR_W       = 18;
  localparam int LP_BCTR_W      = 12;
  localparam int LP_WORD_W      = 36;
  localparam int LP_NXM_TIMEOUT = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    REQ   = 2'd2,
    PUSH  = 2'd3
  } lp_state_t;

  // BAR[1:0] lane selects: the two "high" lanes come from the left half-word,
  // the two "low" lanes from the right half-word.
  localparam logic [1:0] LP_LANE_0 = 2'b00;  // word[25:18]
  localparam logic [1:0] LP_LANE_1 = 2'b01;  // word[33:26]
  localparam logic [1:0] LP_LANE_2 = 2'b10;  // word[7:0]
  localparam logic [1:0] LP_LANE_3 = 2'b11;  // word[15:8]

  function automatic logic [7:0] lp_lane_byte(input logic [LP_WORD_W-1:0] word,
                                              input logic [1:0]           lane);
    logic [7:0] b;
    case (lane)
      LP_LANE_0: b = word[25:18];
      LP_LANE_1: b = word[33:26];
      LP_LANE_2: b = word[7:0];
      default:   b = word[15:8];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lp_dma_rd_if.sv
// LP20 DMA read engine: bus and printer-FIFO handshake bundle.
// master = the DMA engine, slave = the memory bus / FIFO side.
interface lp_dma_rd_if;
  import lp_pkg::*;

  logic                 devREQO;
  logic [LP_BAR_W-1:0]  devADDRO;
  logic [LP_WORD_W-1:0] lpDATAI;
  logic                 devACKI;
  logic [7:0]           fifoDATA;
  logic                 fifoWR;
  logic                 fifoFULL;

  modport master (
    output devREQO, devADDRO, fifoDATA, fifoWR,
    input  lpDATAI, devACKI, fifoFULL
  );

  modport slave (
    input  devREQO, devADDRO, fifoDATA, fifoWR,
    output lpDATAI, devACKI, fifoFULL
  );
endinterface

// File: rtl/lp_nxm_timer.sv
// LP20 DMA read engine: non-existent-memory acknowledge timer.
// Only built when LP_DMA_NXM_EN is defined. Counts cycles while 'start' is
// held; 'clear' or a low 'start' returns it to zero. 'expire' flags the
// TIMEOUT-th consecutive counted cycle.
`ifdef LP_DMA_NXM_EN
module lp_nxm_timer
  import lp_pkg::*;
#(
  parameter int TIMEOUT = LP_NXM_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic expire
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  assign expire = start && !clear && (cnt == CNT_W'(TIMEOUT - 1));

  // Cycle counter for the current request; restarts from zero on every new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!start || clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule
`endif

// File: rtl/lp_dma_rd.sv
// LP20 DMA read engine (lp_dma_rd).
// Fetches one byte per bus request/acknowledge starting at BAR, picks the
// byte lane from BAR[1:0], writes it to the printer FIFO and steps BAR/BCTR
// until BCTR reaches zero. Optional acknowledge timeout (NXM) is enabled by
// defining LP_DMA_NXM_EN.
module lp_dma_rd
  import lp_pkg::*;
`ifdef LP_DMA_NXM_EN
#(
  parameter int NXM_TIMEOUT = LP_NXM_TIMEOUT
)
`endif
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lpCMDGO,
  input  logic                 lpSTOP,
  input  logic [LP_BAR_W-1:0]  lpSETBAR,
  input  logic [LP_BCTR_W-1:0] lpSETBCTR,
  lp_dma_rd_if.master          bus,
  output logic [LP_BAR_W-1:0]  regBAR,
  output logic [LP_BCTR_W-1:0] regBCTR,
  output logic                 lpBUSY,
  output logic                 lpDONE,
  output logic                 lpNXM
);

  lp_state_t  state;
  logic       req_q;
  logic       wr_q;
  logic       done_q;
  logic       stop_pend;   // STOP arrived together with the acknowledge
  logic [7:0] byte_q;

  assign bus.devREQO  = req_q;
  assign bus.devADDRO = regBAR;
  assign bus.fifoDATA = byte_q;
  assign bus.fifoWR   = wr_q;
  assign lpBUSY       = (state != IDLE);
  assign lpDONE       = done_q;

`ifdef LP_DMA_NXM_EN
  logic nxm_q;
  logic nxm_expire;

  lp_nxm_timer #(.TIMEOUT(NXM_TIMEOUT)) u_nxm_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (state == REQ),
    .clear  (lpCMDGO),
    .expire (nxm_expire)
  );

  assign lpNXM = nxm_q;
`else
  assign lpNXM = 1'b0;
`endif

  // Transfer sequencer: GO/restart has top priority, then per-state handling.
  // The GO cycle doubles as the first FIFO check so the request can go out
  // on the very next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      regBAR    <= '0;
      regBCTR   <= '0;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      stop_pend <= 1'b0;
      byte_q    <= '0;
`ifdef LP_DMA_NXM_EN
      nxm_q     <= 1'b0;
`endif
    end else begin
      wr_q <= 1'b0;
      if (lpCMDGO) begin
        regBAR    <= lpSETBAR;
        regBCTR   <= lpSETBCTR;
        stop_pend <= 1'b0;
`ifdef LP_DMA_NXM_EN
        nxm_q     <= 1'b0;
`endif
        if (lpSETBCTR == '0) begin
          state  <= IDLE;
          req_q  <= 1'b0;
          done_q <= 1'b1;
        end else if (!bus.fifoFULL) begin
          state  <= REQ;
          req_q  <= 1'b1;
          done_q <= 1'b0;
        end else begin
          state  <= CHECK;
          req_q  <= 1'b0;
          done_q <= 1'b0;
        end
      end else begin
        case (state)
          CHECK: begin
            if (lpSTOP) begin
              state <= IDLE;
            end else if (regBCTR == '0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else if (!bus.fifoFULL) begin
              state <= REQ;
              req_q <= 1'b1;
            end
          end
          REQ: begin
            if (bus.devACKI) begin
              byte_q    <= lp_lane_byte(bus.lpDATAI, regBAR[1:0]);
              wr_q      <= 1'b1;
              req_q     <= 1'b0;
              stop_pend <= lpSTOP;
              state     <= PUSH;
            end else if (lpSTOP) begin
              req_q <= 1'b0;
              state <= IDLE;
`ifdef LP_DMA_NXM_EN
            end else if (nxm_expire) begin
              req_q <= 1'b0;
              nxm_q <= 1'b1;
              state <= IDLE;
`endif
            end
          end
          PUSH: begin
            regBAR    <= regBAR + 1'b1;
            regBCTR   <= regBCTR + 1'b1;
            stop_pend <= 1'b0;
            state     <= (stop_pend || lpSTOP) ? IDLE : CHECK;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
